// File: rtl/tile_capture5x5.sv
// tile_capture5x5: snoops the pixel-plot stream and rebuilds the 5x5 shape bitmap and colour of one armed tile.
// Optional plot-free timeout in CAPTURE is enabled by defining TILE_CAPTURE_TIMEOUT_EN.
module tile_capture5x5 #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [2:0]  BG_COLOUR      = 3'b000,
    localparam int unsigned TW    = 5,
    localparam int unsigned XW    = 8,
    localparam int unsigned YW    = 7,
    localparam int unsigned CW    = 3,
    localparam int unsigned NPIX  = 25,
    localparam int unsigned CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             arm_i,
    input  logic [TW-1:0]    tile_x_i,
    input  logic [TW-1:0]    tile_y_i,
    input  logic             plot_i,
    input  logic [XW-1:0]    x_i,
    input  logic [YW-1:0]    y_i,
    input  logic [CW-1:0]    colour_i,
    output logic [NPIX-1:0]  shape_o,
    output logic [CW-1:0]    shape_colour_o,
    output logic [CNT_W-1:0] pix_count_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic             col_mismatch_o
);

    // The idle counter is 8 bits wide, so the timeout must fit in 1..256 cycles.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
        $error("tile_capture5x5: TIMEOUT_CYCLES must be in 1..256");
    end

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE, S_ERR} state_e;

    state_e            state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [XW-1:0]     bx_q, bx_d;
    logic [YW-1:0]     by_q, by_d;
    logic [NPIX-1:0]   shape_q, shape_d;
    logic [CW-1:0]     shape_colour_q, shape_colour_d;
    logic [CNT_W-1:0]  pix_count_q, pix_count_d;
    logic              have_colour_q, have_colour_d;
    logic              col_mismatch_q, col_mismatch_d;

    logic [XW-1:0]     dx;
    logic [YW-1:0]     dy;
    logic [CNT_W-1:0]  pix_idx;
    logic              in_tile, take, accept, order_fault, timeout, lit;

    // Tile hit test; subtraction is guarded so a base near the edge never wraps onto low coordinates.
    always_comb begin
        dx          = x_i - bx_q;
        dy          = y_i - by_q;
        in_tile     = (x_i >= bx_q) && (y_i >= by_q) && (dx < XW'(5)) && (dy < YW'(5));
        pix_idx     = CNT_W'(dy) * CNT_W'(5) + CNT_W'(dx);
        take        = (state_q == S_CAPTURE) && plot_i && !arm_i && in_tile;
        accept      = take && (pix_idx == pix_count_q);
        order_fault = take && !accept;
        lit         = (colour_i != BG_COLOUR);
    end

`ifdef TILE_CAPTURE_TIMEOUT_EN
    logic [7:0] idle_q, idle_d;

    always_comb begin
        idle_d  = '0;
        timeout = 1'b0;
        if (state_q == S_CAPTURE && !arm_i && !accept) begin
            idle_d  = idle_q + 8'd1;
            timeout = (idle_q == 8'(TIMEOUT_CYCLES - 1));
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) idle_q <= '0;
        else          idle_q <= idle_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (arm_i) state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (arm_i)                                               state_d = S_CAPTURE;
                else if (order_fault || timeout)                         state_d = S_ERR;
                else if (accept && pix_count_q == CNT_W'(NPIX - 1))      state_d = S_DONE;
            end
            S_DONE:    state_d = arm_i ? S_CAPTURE : S_IDLE;
            S_ERR:     if (arm_i) state_d = S_CAPTURE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Status outputs follow the state being entered, so they are registered alongside it.
    always_comb begin
        busy_d  = (state_d == S_CAPTURE);
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERR);
    end

    // Capture datapath: arm clears everything, an accepted pixel fills the next raster bit.
    always_comb begin
        bx_d           = bx_q;
        by_d           = by_q;
        shape_d        = shape_q;
        shape_colour_d = shape_colour_q;
        pix_count_d    = pix_count_q;
        have_colour_d  = have_colour_q;
        col_mismatch_d = col_mismatch_q;
        if (arm_i) begin
            bx_d           = XW'(tile_x_i) * XW'(5);
            by_d           = YW'(tile_y_i) * YW'(5);
            shape_d        = '0;
            shape_colour_d = '0;
            pix_count_d    = '0;
            have_colour_d  = 1'b0;
            col_mismatch_d = 1'b0;
        end else if (accept) begin
            shape_d[CNT_W'(NPIX - 1) - pix_count_q] = lit;
            pix_count_d = pix_count_q + CNT_W'(1);
            if (lit) begin
                if (!have_colour_q) begin
                    shape_colour_d = colour_i;
                    have_colour_d  = 1'b1;
                end else if (colour_i != shape_colour_q) begin
                    col_mismatch_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            bx_q           <= '0;
            by_q           <= '0;
            shape_q        <= '0;
            shape_colour_q <= '0;
            pix_count_q    <= '0;
            have_colour_q  <= 1'b0;
            col_mismatch_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
            bx_q           <= bx_d;
            by_q           <= by_d;
            shape_q        <= shape_d;
            shape_colour_q <= shape_colour_d;
            pix_count_q    <= pix_count_d;
            have_colour_q  <= have_colour_d;
            col_mismatch_q <= col_mismatch_d;
        end
    end

    assign shape_o        = shape_q;
    assign shape_colour_o = shape_colour_q;
    assign pix_count_o    = pix_count_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign col_mismatch_o = col_mismatch_q;

endmodule
